// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scan controller for the 3x3 whack-a-mole keypad.
// It drives one column low at a time and waits for the lines to settle.
// It then samples the active-low rows and debounces a candidate press.
// One accepted press produces a single-cycle key_valid pulse with key_code = col*3 + row.
// key_held stays high until a debounced release.
// Build option KEYPAD_MULTI_REJECT_EN: when defined, a sample with two or
// more rows low is treated as no key. When undefined, the lowest-index row wins.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] row,
  output logic [2:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_SAMPLE   = 3'd2,
    ST_DEBOUNCE = 3'd3,
    ST_PRESSED  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1'b1);

  state_t           state_r;
  logic [2:0]       col_r;
  logic             key_valid_r;
  logic [3:0]       key_code_r;
  logic             key_held_r;
  logic [1:0]       c_r;
  logic [1:0]       r_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       next_c_s;
  logic             row_low_s;
  logic             sample_none_s;

  // Active-low drive pattern for a column index; unknown index parks all high.
  function automatic logic [2:0] col_drive(input logic [1:0] c);
    case (c)
      2'd0:    col_drive = 3'b110;
      2'd1:    col_drive = 3'b101;
      2'd2:    col_drive = 3'b011;
      default: col_drive = 3'b111;
    endcase
  endfunction

  // Column index after c, wrapping 2 -> 0.
  function automatic logic [1:0] next_col(input logic [1:0] c);
    if (c == 2'd2) next_col = 2'd0;
    else           next_col = c + 2'd1;
  endfunction

  // Lowest-index row that reads low.
  function automatic logic [1:0] first_low(input logic [2:0] rows);
    if (rows[0] == 1'b0)      first_low = 2'd0;
    else if (rows[1] == 1'b0) first_low = 2'd1;
    else                      first_low = 2'd2;
  endfunction

  // True when the tracked row reads low; an illegal index reads as released.
  function automatic logic row_is_low(input logic [2:0] rows, input logic [1:0] r);
    case (r)
      2'd0:    row_is_low = (rows[0] == 1'b0);
      2'd1:    row_is_low = (rows[1] == 1'b0);
      2'd2:    row_is_low = (rows[2] == 1'b0);
      default: row_is_low = 1'b0;
    endcase
  endfunction

  // Two or more rows low at once.
  function automatic logic multi_low(input logic [2:0] rows);
    multi_low = ((~rows[0]) & (~rows[1])) | ((~rows[0]) & (~rows[2])) |
                ((~rows[1]) & (~rows[2]));
  endfunction

  // Key code = column * 3 + row.
  function automatic logic [3:0] code_of(input logic [1:0] c, input logic [1:0] r);
    code_of = ({2'b00, c} * 4'd3) + {2'b00, r};
  endfunction

  assign next_c_s  = next_col(c_r);
  assign row_low_s = row_is_low(row, r_r);

  // Decide whether a SAMPLE cycle sees no usable key.
  always_comb begin
    sample_none_s = 1'b0;
    if (row == 3'b111) begin
      sample_none_s = 1'b1;
    end
`ifdef KEYPAD_MULTI_REJECT_EN
    else if (multi_low(row)) begin
      sample_none_s = 1'b1;
    end
`endif
    else begin
      sample_none_s = 1'b0;
    end
  end

  // Scan/debounce state machine with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      col_r       <= 3'b111;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
      key_held_r  <= 1'b0;
      c_r         <= 2'd0;
      r_r         <= 2'd0;
      cnt_r       <= CNT_ZERO;
    end else begin
      key_valid_r <= 1'b0;
      if (!enable) begin
        // Parking the scanner drops any tracked key silently; key_code is kept.
        state_r    <= ST_IDLE;
        col_r      <= 3'b111;
        key_held_r <= 1'b0;
        c_r        <= 2'd0;
        cnt_r      <= CNT_ZERO;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_SETTLE;
            c_r     <= 2'd0;
            col_r   <= col_drive(2'd0);
            cnt_r   <= CNT_ZERO;
          end
          ST_SETTLE: begin
            if (cnt_r == SETTLE_LAST) begin
              state_r <= ST_SAMPLE;
              cnt_r   <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_SAMPLE: begin
            if (sample_none_s) begin
              state_r <= ST_SETTLE;
              c_r     <= next_c_s;
              col_r   <= col_drive(next_c_s);
              cnt_r   <= CNT_ZERO;
            end else begin
              state_r <= ST_DEBOUNCE;
              r_r     <= first_low(row);
              cnt_r   <= CNT_ZERO;
            end
          end
          ST_DEBOUNCE: begin
            if (row_low_s) begin
              if (cnt_r == DEBOUNCE_LAST) begin
                state_r <= ST_PRESSED;
                cnt_r   <= CNT_ZERO;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              // Bounce: abandon the candidate and keep scanning.
              state_r <= ST_SETTLE;
              c_r     <= next_c_s;
              col_r   <= col_drive(next_c_s);
              cnt_r   <= CNT_ZERO;
            end
          end
          ST_PRESSED: begin
            // First PRESSED cycle announces the key; key_held marks it as done.
            if (!key_held_r) begin
              key_valid_r <= 1'b1;
              key_held_r  <= 1'b1;
              key_code_r  <= code_of(c_r, r_r);
            end
            if (!row_low_s) begin
              if (cnt_r == DEBOUNCE_LAST) begin
                key_held_r <= 1'b0;
                state_r    <= ST_SETTLE;
                c_r        <= next_c_s;
                col_r      <= col_drive(next_c_s);
                cnt_r      <= CNT_ZERO;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            col_r      <= 3'b111;
            key_held_r <= 1'b0;
            cnt_r      <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign col       = col_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign key_held  = key_held_r;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Column-scan controller for the 3x3 whack-a-mole keypad. It drives one column low at a time, waits for the lines to settle, and samples the three active-low row inputs. Each candidate press is debounced with a cycle counter. For each debounced press it emits a one-cycle key event and a 4-bit key code, and the game FSM consumes these directly.

Parameters:
SETTLE_CYCLES, 2, cycles a column is driven before rows are sampled (>=1)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or a release (>=1)
CNT_W, 4, width of the internal settle/debounce counter; must hold max(SETTLE_CYCLES, DEBOUNCE_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  scan enable; 0 parks the scanner
row  input  3  keypad rows, active-low (0 = key closed on driven column)
col  output  3  column drives, active-low, one-hot-low while scanning
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  col_index*3 + row_index (0..8), held until next accepted press
key_held  output  1  high from key_valid until debounced release

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset). All outputs are registered.
- Reset values: state=IDLE, col=3'b111, key_valid=0, key_code=0, key_held=0, column index c=0, counter=0.
- States: IDLE, SETTLE, SAMPLE, DEBOUNCE, PRESSED.
- IDLE: col=111. If enable=1, go to SETTLE with c=0.
- SETTLE: col drives bit c low. After SETTLE_CYCLES cycles, go to SAMPLE.
- SAMPLE (1 cycle): if row==111, set c=(c==2)?0:c+1 and go to SETTLE. Otherwise latch r = lowest index with row[r]==0, clear the counter and go to DEBOUNCE.
- DEBOUNCE: if row[r]==0, increment the counter; if row[r]==1, abort (no event), advance c and go to SETTLE.
- DEBOUNCE accept: on the DEBOUNCE_CYCLES-th consecutive low, go to PRESSED. In the next cycle, key_valid=1 for exactly one cycle, key_code=c*3+r and key_held=1.
- PRESSED: col stays on c and the counter counts consecutive row[r]==1. Any low sample clears the counter.
- PRESSED release: on the DEBOUNCE_CYCLES-th consecutive high, key_held=0, advance c and go to SETTLE. No event is generated for release.
- Only one key is tracked at a time. Other keys pressed during PRESSED are ignored until release.
- Column wrap: 2 -> 0. Scan period with no keys is 3*(SETTLE_CYCLES+1) cycles.
- enable=0 in any state: next cycle go to IDLE with col=111 and key_held=0. No key_valid is issued. key_code is retained. Re-enable restarts at c=0.
- Asynchronous reset mid-operation: all outputs return to reset values immediately. A press in flight is discarded.
- Press latency: key_valid appears SETTLE_CYCLES+1+DEBOUNCE_CYCLES+1 cycles after the column is first driven, for a key held stable.

Optional Feature:
KEYPAD_MULTI_REJECT_EN
- Defined: in SAMPLE, two or more rows low counts as invalid. Treat it as no key, advance c and go to SETTLE, with no event.
- Undefined: the lowest-index low row wins, as described above.

Test Plan:
1. Reset low, then high, enable=1, row=111 -> col steps 110(3 cycles), 101(3), 011(3), then 110; key_valid never asserts.
2. Hold row=011 (row2) while col=101 (c=1), stable for 20 cycles -> exactly one key_valid pulse with key_code=5 and key_held=1; key_held drops 4 cycles after row returns to 111.
3. Bounce: row2 low for 2 cycles then high during DEBOUNCE -> no key_valid, key_code unchanged, next col=011.
4. In PRESSED, row high for 2 cycles then low again -> key_held stays 1, no second pulse; a later 4-cycle high releases.
5. At c=0, row=100 -> key_code=0 and key_valid pulses. With KEYPAD_MULTI_REJECT_EN defined -> no pulse and scan advances to col=101.
6. enable dropped in PRESSED -> next cycle col=111 and key_held=0. Separately, assert reset mid-DEBOUNCE -> outputs at reset values without waiting for clk.
